// File: rtl/shift_register_with_valid_ready.sv
// ---------------------------------------------------------------------------
// shift_register_with_valid_ready
//
// A depth-stage data pipeline in which every stage carries its own valid bit.
// Both ends use a ready/valid handshake, so a consumer that stalls can hold
// the pipe back. It serves as a delay or balancing line beside arithmetic
// pipelines. With no stalls, a word accepted at the input appears at the
// output exactly depth cycles later. The pipe sustains one word per cycle
// whenever out_rdy stays high.
//
// Parameters
//   width    : data width in bits (>= 1)
//   depth    : number of register stages, i.e. latency with no stalls (>= 1)
//   collapse : 0 -> global stall: the whole pipe freezes while the output
//                   word waits
//              1 -> per-stage stall: words keep moving forward into empty
//                   stages, so bubbles are squeezed out
//
// Ports
//   clk      in   1                clock, all state on the rising edge
//   rst      in   1                asynchronous active-high reset
//   flush    in   1                synchronous clear of all stage valids
//   in_vld   in   1                upstream offers in_data
//   in_rdy   out  1                block accepts in_data this cycle
//   in_data  in   width            upstream data
//   out_vld  out  1                last stage holds a valid word
//   out_rdy  in   1                downstream accepts this cycle
//   out_data out  width            data of the last stage
//   count    out  clog2(depth+1)   number of valid stages (registered)
// ---------------------------------------------------------------------------
module shift_register_with_valid_ready #(
    parameter int width    = 8,
    parameter int depth    = 8,
    parameter bit collapse = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_vld,
    output logic                           in_rdy,
    input  logic [width-1:0]               in_data,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic [width-1:0]               out_data,
    output logic [$clog2(depth+1)-1:0]     count
);

    localparam int cnt_w = $clog2(depth + 1);

    logic [depth-1:0] vld;
    logic [depth-1:0] vld_next;
    logic [depth-1:0] rdy;
    logic [depth-1:0] en;
    logic [width-1:0] data [depth];
    logic             adv;
    logic             chain;
    logic [cnt_w-1:0] cnt_next;

    // Per-stage ready chain used by the collapsing mode. A stage can take a
    // new word if it is empty, or if its own word moves on this cycle. The
    // chain is walked from the output backwards through a running variable,
    // so no bit of rdy ever feeds another bit of the same vector.
    always_comb begin
        rdy   = '0;
        chain = out_rdy;
        for (int i = depth - 1; i >= 0; i--) begin
            chain  = !vld[i] || chain;
            rdy[i] = chain;
        end
    end

    // Global advance for the freezing mode: the whole pipe steps whenever the
    // output stage is empty or is being consumed.
    assign adv = !vld[depth-1] || out_rdy;

    // Stage load enables. Both modes share the datapath below. Only the rule
    // that decides which stages step this cycle differs between them.
    always_comb begin
        en = '0;
        if (collapse) begin
            en = rdy;
        end else begin
            en = {depth{adv}};
        end
    end

    // Flush blocks new input so that a word can never slip in during the
    // same cycle that clears everything.
    assign in_rdy = en[0] && !flush;

    // Next valid vector. A stage that loads from an empty source turns into
    // a bubble. A stage that does not load keeps its word. Flush overrides
    // everything.
    always_comb begin
        vld_next = vld;
        if (en[0]) begin
            vld_next[0] = in_vld;
        end
        for (int i = 1; i < depth; i++) begin
            if (en[i]) begin
                vld_next[i] = vld[i-1];
            end
        end
        if (flush) begin
            vld_next = '0;
        end
    end

    // Occupancy of the next state. It is registered alongside the valids so
    // that count always describes the stages visible in the same cycle.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < depth; i++) begin
            cnt_next = cnt_next + cnt_w'(vld_next[i]);
        end
    end

    // Valid bits and count. An asynchronous reset discards all contents at
    // once, with no partial shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld   <= '0;
            count <= '0;
        end else begin
            vld   <= vld_next;
            count <= cnt_next;
        end
    end

    // Data registers load only from a valid source. This means a stage that
    // becomes a bubble keeps its last word, and out_data never shows junk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                data[i] <= '0;
            end
        end else begin
            if (in_vld && in_rdy) begin
                data[0] <= in_data;
            end
            for (int i = 1; i < depth; i++) begin
                if (en[i] && vld[i-1]) begin
                    data[i] <= data[i-1];
                end
            end
        end
    end

    assign out_vld  = vld[depth-1];
    assign out_data = data[depth-1];

endmodule

// File: tb/tb_shift_register_with_valid_ready.sv
// ---------------------------------------------------------------------------
// tb_shift_register_with_valid_ready
//
// Four instances of the pipeline run side by side:
//   0 : depth 4, freezing mode
//   1 : depth 4, collapsing mode
//   2 : depth 1, freezing mode
//   3 : depth 1, collapsing mode
//
// Each instance has its own scoreboard. A word is pushed when the input
// handshake completes. A monitor pops the scoreboard on every output
// handshake and compares the data. Flush and reset discard the queued words
// that can no longer come out.
//
// The directed sequences check cycle-exact expectations worked out by hand:
// latency, stall, bubble squeezing, flush and reset. The depth-1 instances
// are then compared against a one-bit occupancy model under random traffic.
// ---------------------------------------------------------------------------
module tb_shift_register_with_valid_ready;

    logic       clk;
    logic       rst;
    logic       in_vld   [4];
    logic [7:0] in_data  [4];
    logic       out_rdy  [4];
    logic       flush    [4];
    logic       in_rdy   [4];
    logic       out_vld  [4];
    logic [7:0] out_data [4];
    logic [2:0] count4   [2];
    logic [0:0] count1   [2];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [7:0] sb_mem [4][256];
    int         sb_wr  [4] = '{default: 0};
    int         sb_rd  [4] = '{default: 0};

    int t1_cnt  [8]  = '{0, 1, 2, 3, 3, 2, 1, 0};
    int t2_cnt  [12] = '{0, 1, 2, 3, 4, 4, 4, 4, 3, 2, 1, 0};
    int t3_cnt1 [13] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 3, 2, 1, 0};
    int t3_cnt0 [8]  = '{0, 1, 1, 2, 2, 2, 2, 2};

    shift_register_with_valid_ready #(.width(8), .depth(4), .collapse(1'b0)) u_d4_c0 (
        .clk(clk), .rst(rst), .flush(flush[0]), .in_vld(in_vld[0]), .in_rdy(in_rdy[0]),
        .in_data(in_data[0]), .out_vld(out_vld[0]), .out_rdy(out_rdy[0]),
        .out_data(out_data[0]), .count(count4[0]));

    shift_register_with_valid_ready #(.width(8), .depth(4), .collapse(1'b1)) u_d4_c1 (
        .clk(clk), .rst(rst), .flush(flush[1]), .in_vld(in_vld[1]), .in_rdy(in_rdy[1]),
        .in_data(in_data[1]), .out_vld(out_vld[1]), .out_rdy(out_rdy[1]),
        .out_data(out_data[1]), .count(count4[1]));

    shift_register_with_valid_ready #(.width(8), .depth(1), .collapse(1'b0)) u_d1_c0 (
        .clk(clk), .rst(rst), .flush(flush[2]), .in_vld(in_vld[2]), .in_rdy(in_rdy[2]),
        .in_data(in_data[2]), .out_vld(out_vld[2]), .out_rdy(out_rdy[2]),
        .out_data(out_data[2]), .count(count1[0]));

    shift_register_with_valid_ready #(.width(8), .depth(1), .collapse(1'b1)) u_d1_c1 (
        .clk(clk), .rst(rst), .flush(flush[3]), .in_vld(in_vld[3]), .in_rdy(in_rdy[3]),
        .in_data(in_data[3]), .out_vld(out_vld[3]), .out_rdy(out_rdy[3]),
        .out_data(out_data[3]), .count(count1[1]));

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int got, input int expected);
        tests_run++;
        if (got !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input int k, input logic v, input logic [7:0] d,
                                 input logic ordy, input logic fl);
        in_vld[k]  = v;
        in_data[k] = d;
        out_rdy[k] = ordy;
        flush[k]   = fl;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(k, 1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int cnt_of(input int k);
        if (k < 2) begin
            return int'(count4[k]);
        end
        return int'(count1[k-2]);
    endfunction

    // Let every instance run dry, then hand control back with idle inputs.
    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            step();
            idle_all();
            #1;
            done = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (cnt_of(k) != 0 || out_vld[k]) begin
                    done = 1'b0;
                end
            end
        end
        checkOutput("drain completes", int'(done), 1);
    endtask

    // Scoreboard monitor. It samples on the falling edge, when all handshake
    // signals are stable. An output handshake is serviced before a flush
    // clears the queue, because the word leaving in the flush cycle counts
    // as consumed.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int k = 0; k < 4; k++) begin
                    sb_rd[k] = sb_wr[k];
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (out_vld[k] && out_rdy[k]) begin
                        if (sb_rd[k] == sb_wr[k]) begin
                            checkOutput($sformatf("inst%0d unexpected output", k), int'(out_data[k]), -1);
                        end else begin
                            checkOutput($sformatf("inst%0d out word", k), int'(out_data[k]),
                                        int'(sb_mem[k][sb_rd[k] % 256]));
                            sb_rd[k]++;
                        end
                    end
                    if (flush[k]) begin
                        sb_rd[k] = sb_wr[k];
                    end
                    if (in_vld[k] && in_rdy[k]) begin
                        sb_mem[k][sb_wr[k] % 256] = in_data[k];
                        sb_wr[k]++;
                    end
                end
            end
        end
    end

    // Directed sequences followed by random depth-1 traffic.
    initial begin
        bit         mv     [2];
        bit         pend   [2];
        logic       r_vld  [2];
        logic [7:0] r_data [2];
        logic       r_ordy [2];
        logic       r_fl   [2];
        bit         exp_rdy;
        bit         take;

        rst = 1'b1;
        idle_all();
        #2;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("reset u%0d out_vld", k), int'(out_vld[k]), 0);
            checkOutput($sformatf("reset u%0d count", k), cnt_of(k), 0);
            checkOutput($sformatf("reset u%0d out_data", k), int'(out_data[k]), 0);
        end
        step();
        step();
        rst = 1'b0;

        // Three back-to-back words with no stall: latency depth, full throughput.
        for (int k = 0; k < 8; k++) begin
            step();
            for (int u = 0; u < 2; u++) begin
                applyStimulus(u, k < 3, (k < 3) ? 8'(8'h11 * (k + 1)) : 8'h00, 1'b1, 1'b0);
            end
            #1;
            for (int u = 0; u < 2; u++) begin
                checkOutput($sformatf("t1 u%0d in_rdy", u), int'(in_rdy[u]), 1);
                checkOutput($sformatf("t1 u%0d out_vld", u), int'(out_vld[u]), int'(k >= 4 && k <= 6));
                if (k >= 4 && k <= 6) begin
                    checkOutput($sformatf("t1 u%0d out_data", u), int'(out_data[u]), 17 * (k - 3));
                end
                checkOutput($sformatf("t1 u%0d count", u), cnt_of(u), t1_cnt[k]);
            end
        end

        // Fill to four words, stall the output for three cycles while a word
        // waits upstream, then release and drain.
        for (int k = 0; k < 12; k++) begin
            step();
            for (int u = 0; u < 2; u++) begin
                applyStimulus(u, k <= 6, (k <= 3) ? 8'(8'hA0 + k) : 8'hEE, k >= 7, 1'b0);
            end
            #1;
            for (int u = 0; u < 2; u++) begin
                checkOutput($sformatf("t2 u%0d in_rdy", u), int'(in_rdy[u]), int'(!(k >= 4 && k <= 6)));
                checkOutput($sformatf("t2 u%0d count", u), cnt_of(u), t2_cnt[k]);
                checkOutput($sformatf("t2 u%0d out_vld", u), int'(out_vld[u]), int'(k >= 4 && k <= 10));
                if (k >= 4 && k <= 10) begin
                    checkOutput($sformatf("t2 u%0d out_data", u), int'(out_data[u]),
                                (k <= 7) ? 8'hA0 : 8'hA0 + (k - 7));
                end
            end
        end

        // Words separated by bubbles while the output is blocked. The
        // collapsing pipe squeezes them together and fills up. The freezing
        // pipe stops at two words with C held upstream.
        for (int k = 0; k < 13; k++) begin
            step();
            applyStimulus(1, (k <= 6) && (k % 2 == 0), 8'(8'h41 + k / 2), k >= 8, 1'b0);
            applyStimulus(0, (k == 0) || (k == 2) || (k >= 4 && k <= 7),
                          (k == 0) ? 8'h41 : ((k == 2) ? 8'h42 : 8'h43), k >= 8, 1'b0);
            #1;
            checkOutput("t3 u1 in_rdy", int'(in_rdy[1]), int'(k != 7));
            checkOutput("t3 u1 count", cnt_of(1), t3_cnt1[k]);
            checkOutput("t3 u1 out_vld", int'(out_vld[1]), int'(k >= 4 && k <= 11));
            if (k >= 4 && k <= 11) begin
                checkOutput("t3 u1 out_data", int'(out_data[1]), (k <= 8) ? 8'h41 : 8'h41 + (k - 8));
            end
            if (k <= 7) begin
                checkOutput("t3 u0 in_rdy", int'(in_rdy[0]), int'(k <= 3));
                checkOutput("t3 u0 count", cnt_of(0), t3_cnt0[k]);
                checkOutput("t3 u0 out_vld", int'(out_vld[0]), int'(k >= 4));
                if (k >= 4) begin
                    checkOutput("t3 u0 out_data", int'(out_data[0]), 8'h41);
                end
            end
        end
        drain();

        // Flush while a word leaves and another is offered.
        for (int k = 0; k < 7; k++) begin
            step();
            for (int u = 0; u < 2; u++) begin
                if (k <= 3) applyStimulus(u, 1'b1, 8'(8'h61 + k), 1'b0, 1'b0);
                else if (k == 4) applyStimulus(u, 1'b0, 8'h00, 1'b0, 1'b0);
                else if (k == 5) applyStimulus(u, 1'b1, 8'h99, 1'b1, 1'b1);
                else applyStimulus(u, 1'b0, 8'h00, 1'b1, 1'b0);
            end
            #1;
            for (int u = 0; u < 2; u++) begin
                if (k == 4) begin
                    checkOutput($sformatf("t4 u%0d full count", u), cnt_of(u), 4);
                    checkOutput($sformatf("t4 u%0d full out_vld", u), int'(out_vld[u]), 1);
                end
                if (k == 5) begin
                    checkOutput($sformatf("t4 u%0d flush in_rdy", u), int'(in_rdy[u]), 0);
                    checkOutput($sformatf("t4 u%0d flush out_data", u), int'(out_data[u]), 8'h61);
                end
                if (k == 6) begin
                    checkOutput($sformatf("t4 u%0d post-flush count", u), cnt_of(u), 0);
                    checkOutput($sformatf("t4 u%0d post-flush out_vld", u), int'(out_vld[u]), 0);
                    checkOutput($sformatf("t4 u%0d post-flush in_rdy", u), int'(in_rdy[u]), 1);
                end
            end
        end

        // Asynchronous reset pulse in the middle of a cycle with three words held.
        for (int k = 0; k < 4; k++) begin
            step();
            for (int u = 0; u < 2; u++) begin
                applyStimulus(u, k <= 2, 8'(8'h71 + k), 1'b0, 1'b0);
            end
            #1;
        end
        checkOutput("t5 u0 count before reset", cnt_of(0), 3);
        checkOutput("t5 u1 count before reset", cnt_of(1), 3);
        #1;
        rst = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("t5 u%0d async out_vld", u), int'(out_vld[u]), 0);
            checkOutput($sformatf("t5 u%0d async count", u), cnt_of(u), 0);
            checkOutput($sformatf("t5 u%0d async out_data", u), int'(out_data[u]), 0);
        end
        #3;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            for (int u = 0; u < 2; u++) begin
                applyStimulus(u, k == 0, 8'h5A, 1'b1, 1'b0);
            end
            #1;
            for (int u = 0; u < 2; u++) begin
                checkOutput($sformatf("t5 u%0d latency out_vld", u), int'(out_vld[u]), int'(k == 4));
                if (k == 4) begin
                    checkOutput($sformatf("t5 u%0d latency out_data", u), int'(out_data[u]), 8'h5A);
                end
            end
        end
        drain();

        // Random traffic on the depth-1 instances against a one-bit model.
        // A word that is offered but not taken stays on the input until it is.
        for (int j = 0; j < 2; j++) begin
            mv[j]   = 1'b0;
            pend[j] = 1'b0;
        end
        for (int n = 0; n < 10000; n++) begin
            step();
            for (int j = 0; j < 2; j++) begin
                r_fl[j]   = ($urandom_range(0, 31) == 0);
                r_ordy[j] = ($urandom_range(0, 3) != 0);
                if (!pend[j]) begin
                    r_vld[j]  = 1'($urandom_range(0, 1));
                    r_data[j] = 8'($urandom);
                end
                applyStimulus(j + 2, r_vld[j], r_data[j], r_ordy[j], r_fl[j]);
            end
            #1;
            for (int j = 0; j < 2; j++) begin
                exp_rdy = (!mv[j] || r_ordy[j]) && !r_fl[j];
                checkOutput($sformatf("t6 u%0d in_rdy", j + 2), int'(in_rdy[j+2]), int'(exp_rdy));
                checkOutput($sformatf("t6 u%0d count", j + 2), cnt_of(j + 2), int'(mv[j]));
                checkOutput($sformatf("t6 u%0d out_vld", j + 2), int'(out_vld[j+2]), int'(mv[j]));
                take = r_vld[j] && exp_rdy;
                if (r_fl[j]) mv[j] = 1'b0;
                else if (take) mv[j] = 1'b1;
                else if (mv[j] && r_ordy[j]) mv[j] = 1'b0;
                pend[j] = r_vld[j] && !take;
            end
        end
        drain();

        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("inst%0d leftover words", k), sb_wr[k] - sb_rd[k], 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
